// File: rtl/txstream_pkg.sv
// txstream_pkg
//   Shared definitions for the TX IQ de-streamer: the packet geometry
//   constants, the byte-parser state type and a saturating counter helper.
package txstream_pkg;

    localparam int unsigned TX_PAYLOAD_LEN   = 1028;
    localparam int unsigned SAMPLES_PER_PKT  = 256;
    localparam int unsigned SEQ_BYTES        = 4;
    localparam int unsigned BYTES_PER_SAMPLE = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEQ,
        ST_I1,
        ST_I0,
        ST_Q1,
        ST_Q0,
        ST_DRAIN
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/txstream_seqchk.sv
// txstream_seqchk
//   Packet sequence tracker. Holds the sequence number expected in the next
//   packet. The first packet seen after arming only loads the expectation;
//   later packets flag an error when their number differs from it. The
//   expectation always follows the received number + 1 (32-bit wrap is
//   therefore not an error).
//   Only instantiated when TXSTREAM_SEQCHK_EN is defined.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset (unarms)
//   i_rearm         level: drop the armed state (streaming disabled)
//   i_strobe        one cycle: i_seq holds a complete received seq number
//   i_seq           received 32-bit sequence number
//   o_err           combinational error pulse, coincident with i_strobe
module txstream_seqchk (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rearm,
    input  logic        i_strobe,
    input  logic [31:0] i_seq,
    output logic        o_err
);

    logic        r_armed;
    logic [31:0] r_expected;

    assign o_err = i_strobe & r_armed & (i_seq != r_expected);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_armed    <= 1'b0;
            r_expected <= '0;
        end else if (i_rearm) begin
            r_armed    <= 1'b0;
        end else if (i_strobe) begin
            r_armed    <= 1'b1;
            r_expected <= i_seq + 32'd1;
        end
    end

endmodule

// File: rtl/txstream.sv
// txstream
//   TX IQ de-streamer. Parses host UDP payloads (4-byte big-endian sequence
//   number followed by 256 samples of {I hi, I lo, Q hi, Q lo}) and issues one
//   32-bit {I,Q} write per sample to the TX FIFO.
//   Optional feature: define TXSTREAM_SEQCHK_EN to enable sequence-gap
//   counting; otherwise seq bytes are discarded and seq_err_count is 0.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   run, have_ip      streaming enable qualifiers
//   udp_rx_active     payload byte valid (contiguous within a packet)
//   udp_rx_data       payload byte
//   udp_rx_length     payload length, valid on the first active cycle
//   tx_wrfull         TX FIFO full
//   tx_data           {I[15:0], Q[15:0]}, registered
//   tx_wrreq          one-cycle FIFO write strobe, registered
//   seq_err_count     saturating count of sequence gaps
//   drop_count        saturating count of dropped packets / samples
module txstream
    import txstream_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        have_ip,
    input  logic        udp_rx_active,
    input  logic [7:0]  udp_rx_data,
    input  logic [10:0] udp_rx_length,
    input  logic        tx_wrfull,
    output logic [31:0] tx_data,
    output logic        tx_wrreq,
    output logic [15:0] seq_err_count,
    output logic [15:0] drop_count
);

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_seq_idx, w_seq_idx_nxt;
    logic [7:0]  r_samp, w_samp_nxt;
    logic [7:0]  r_i_hi, r_i_lo, r_q_hi;
    logic        r_act_d;
    logic [31:0] r_tx_data;
    logic        r_tx_wrreq;
    logic [15:0] r_drop;

    logic        w_ok;
    logic        w_drop_inc;
    logic        w_seq_byte;
    logic        w_seq_last;
    logic        w_cap_ihi, w_cap_ilo, w_cap_qhi;
    logic        w_do_write;

    assign w_ok = run & have_ip;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_seq_idx <= '0;
            r_samp    <= '0;
            r_act_d   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_seq_idx <= w_seq_idx_nxt;
            r_samp    <= w_samp_nxt;
            r_act_d   <= udp_rx_active;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_seq_idx_nxt = r_seq_idx;
        w_samp_nxt    = r_samp;
        w_drop_inc    = 1'b0;
        w_seq_byte    = 1'b0;
        w_seq_last    = 1'b0;
        w_cap_ihi     = 1'b0;
        w_cap_ilo     = 1'b0;
        w_cap_qhi     = 1'b0;
        w_do_write    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (udp_rx_active) begin
                    // Active in IDLE while it was already active last cycle
                    // means bytes beyond a complete packet: drain them.
                    if (r_act_d || !w_ok) begin
                        w_state_nxt = ST_DRAIN;
                    end else if (udp_rx_length == 11'(TX_PAYLOAD_LEN)) begin
                        w_seq_byte    = 1'b1;
                        w_seq_idx_nxt = '0;
                        w_samp_nxt    = '0;
                        w_state_nxt   = ST_SEQ;
                    end else begin
                        w_drop_inc  = 1'b1;
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!udp_rx_active) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEQ, ST_I1, ST_I0, ST_Q1, ST_Q0: begin
                if (!udp_rx_active) begin
                    // Truncated packet; any partial sample is abandoned.
                    w_drop_inc  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (!w_ok) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    case (r_state)
                        ST_SEQ: begin
                            w_seq_byte = 1'b1;
                            if (r_seq_idx == 2'(SEQ_BYTES - 2)) begin
                                w_seq_last  = 1'b1;
                                w_state_nxt = ST_I1;
                            end else begin
                                w_seq_idx_nxt = r_seq_idx + 2'd1;
                            end
                        end
                        ST_I1: begin
                            w_cap_ihi   = 1'b1;
                            w_state_nxt = ST_I0;
                        end
                        ST_I0: begin
                            w_cap_ilo   = 1'b1;
                            w_state_nxt = ST_Q1;
                        end
                        ST_Q1: begin
                            w_cap_qhi   = 1'b1;
                            w_state_nxt = ST_Q0;
                        end
                        ST_Q0: begin
                            w_do_write = 1'b1;
                            if (r_samp == 8'(SAMPLES_PER_PKT - 1)) begin
                                w_state_nxt = ST_IDLE;
                            end else begin
                                w_samp_nxt  = r_samp + 8'd1;
                                w_state_nxt = ST_I1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_i_hi     <= '0;
            r_i_lo     <= '0;
            r_q_hi     <= '0;
            r_tx_data  <= '0;
            r_tx_wrreq <= 1'b0;
            r_drop     <= '0;
        end else begin
            if (w_cap_ihi) r_i_hi <= udp_rx_data;
            if (w_cap_ilo) r_i_lo <= udp_rx_data;
            if (w_cap_qhi) r_q_hi <= udp_rx_data;
            r_tx_wrreq <= w_do_write & ~tx_wrfull;
            if (w_do_write && !tx_wrfull) begin
                r_tx_data <= {r_i_hi, r_i_lo, r_q_hi, udp_rx_data};
            end
            // A full FIFO costs the sample, not the packet.
            if (w_drop_inc || (w_do_write && tx_wrfull)) begin
                r_drop <= sat_inc16(r_drop);
            end
        end
    end

    assign tx_data    = r_tx_data;
    assign tx_wrreq   = r_tx_wrreq;
    assign drop_count = r_drop;

`ifdef TXSTREAM_SEQCHK_EN
    logic [23:0] r_seq_hi;
    logic [15:0] r_seq_err;
    logic        w_seq_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seq_hi  <= '0;
            r_seq_err <= '0;
        end else begin
            if (w_seq_byte) r_seq_hi <= {r_seq_hi[15:0], udp_rx_data};
            if (w_seq_err)  r_seq_err <= sat_inc16(r_seq_err);
        end
    end

    // Streaming disabled keeps the tracker unarmed, so the first packet
    // after run/have_ip return only reloads the expectation.
    txstream_seqchk u_seqchk (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_rearm  (~w_ok),
        .i_strobe (w_seq_last),
        .i_seq    ({r_seq_hi, udp_rx_data}),
        .o_err    (w_seq_err)
    );

    assign seq_err_count = r_seq_err;
`else
    logic w_unused_seq;
    assign w_unused_seq  = w_seq_byte ^ w_seq_last;
    assign seq_err_count = '0;
`endif

endmodule

// File: doc/txstream.md
# txstream

TX IQ de-streaming block: takes the UDP payload byte stream arriving from the host PC on the TX IQ port and unpacks it into 32-bit IQ words (16-bit I, 16-bit Q) for the TX sample FIFO feeding the modulator. It sits between the Ethernet UDP receive path and the TX FIFO, as the host-to-radio counterpart of the RX IQ streamer. Control stays on SPI; this block carries samples only.

## Interface
- TX_PAYLOAD_LEN, 1028: expected UDP payload bytes (4 seq + 256 samples × 4).
- SAMPLES_PER_PKT, 256: IQ samples per packet.

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  host streaming enabled.
- have_ip  in  1  IP address acquired.
- udp_rx_active  in  1  high for each valid payload byte; contiguous within a packet, low ≥1 cycle between packets.
- udp_rx_data  in  8  payload byte, valid when udp_rx_active.
- udp_rx_length  in  11  payload length, valid on first active cycle.
- tx_wrfull  in  1  TX FIFO full.
- tx_data  out  32  {I[15:0], Q[15:0]}.
- tx_wrreq  out  1  one-cycle FIFO write strobe.
- seq_err_count  out  16  saturating count of sequence gaps.
- drop_count  out  16  saturating count of dropped packets/samples.

## Operation
- States: IDLE, SEQ, I1, I0, Q1, Q0, DRAIN.
- IDLE: on udp_rx_active with run & have_ip: if udp_rx_length == TX_PAYLOAD_LEN, consume byte as seq[31:24], → SEQ; else drop_count+1, → DRAIN. Active while ~run | ~have_ip → DRAIN, no count.
- SEQ: collect seq[23:0] big-endian over three bytes, → I1.
- I1/I0/Q1/Q0: capture I hi, I lo, Q hi, Q lo; on Q0 byte issue write (see Timing); → I1, or IDLE after sample 256.
- Bytes after 1028th in same burst: → DRAIN.
- udp_rx_active falling in any non-IDLE state other than after sample 256: truncated packet, drop_count+1, partial sample discarded, → IDLE.
- DRAIN: ignore bytes until udp_rx_active low, → IDLE.
- tx_wrfull at write time: sample not written, drop_count+1, stream continues.
- run or have_ip low mid-packet: → DRAIN immediately, no further writes; sequence tracker re-armed.
- Counters saturate at 16'hFFFF; cleared only by reset.

## Timing
- Reset: state IDLE, tx_data 0, tx_wrreq 0, seq_err_count 0, drop_count 0, tracker unarmed.
- tx_data/tx_wrreq registered: tx_wrreq high exactly one cycle, the cycle after the Q lo byte; tx_data stable that cycle.
- Back-to-back bytes give one write per 4 cycles; gaps in udp_rx_active inside a packet are not allowed (treated as truncation).
- Sequence decision registered one cycle after 4th seq byte; count update visible then.
- reset wins over every simultaneous event.

## Configuration
- TXSTREAM_SEQCHK_EN defined: tracker holds expected seq; first packet after arm (reset, run/have_ip rising) loads expected = seq+1 without error; thereafter mismatch → seq_err_count+1 (once per packet, regardless of gap size), expected = received+1; wrap 32'hFFFFFFFF → 0 is not an error.
- Undefined: seq bytes consumed and discarded, seq_err_count tied to 0, tracker logic absent.

## Structure
- Package txstream_pkg: state enum, TX_PAYLOAD_LEN, SAMPLES_PER_PKT, SEQ_BYTES = 4, BYTES_PER_SAMPLE = 4.
- Sub-module txstream_seqchk: 32-bit seq input + strobe, arm/re-arm, error pulse; instantiated only under TXSTREAM_SEQCHK_EN.

## Test plan
- run=1, have_ip=1, one 1028-byte packet seq 0, samples I=n, Q=~n → 256 writes, tx_data={n,~n}, drop_count 0.
- Packets seq 5 then 7 (macro on) → seq_err_count=1; then seq 8 → stays 1; seq FFFFFFFF then 0 → no increment.
- udp_rx_length=1000 → no writes, drop_count=1, next valid packet processed fully.
- udp_rx_active drops after 4+4×10+2 bytes → 10 writes, drop_count=1, state IDLE.
- tx_wrfull high during samples 100–109 → 246 writes, drop_count=10.
- run low mid-packet at sample 50 → 50 writes then none; reset asserted mid-packet → all outputs 0 next cycle.
